// File: rtl/rv_pkg.sv
// rv_pkg: shared RV32I opcode, funct3 and EX/MEM pipeline definitions.
package rv_pkg;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  typedef enum logic [2:0] {
    F3_ADD = 3'b000, F3_SLL = 3'b001, F3_SLT = 3'b010, F3_SLTU = 3'b011,
    F3_XOR = 3'b100, F3_SR = 3'b101, F3_OR = 3'b110, F3_AND = 3'b111
  } alu_f3_t;
  typedef enum logic [2:0] {
    BR_EQ = 3'b000, BR_NE = 3'b001, BR_LT = 3'b100,
    BR_GE = 3'b101, BR_LTU = 3'b110, BR_GEU = 3'b111
  } br_f3_t;
  typedef struct packed {
    logic [31:0] result;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        mem_to_reg;
  } ex_mem_t;
  // Loads in EX/MEM have no data yet, so only ALU-type results are forwarded from there.
  function automatic logic [31:0] forward(input logic [4:0] rs, input ex_mem_t ex,
                                          input logic wb_we, input logic [4:0] wb_rd,
                                          input logic [31:0] wb_data, input logic [31:0] reg_data);
    return (ex.reg_write && !ex.mem_read && ex.rd != 5'd0 && ex.rd == rs) ? ex.result :
           (wb_we && wb_rd != 5'd0 && wb_rd == rs) ? wb_data : reg_data;
  endfunction
endpackage

// File: rtl/alu.sv
// alu: combinational RV32I integer ALU selected by funct3, alt picks SUB/SRA.
module alu
  import rv_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  funct3,
  input  logic        alt,
  output logic [31:0] y
);
  logic [4:0]  sh;
  logic [31:0] sra;
  always_comb begin
    sh = b[4:0];
    sra = $signed(a) >>> sh;
    y = funct3 == F3_ADD  ? (alt ? a - b : a + b) :
        funct3 == F3_SLL  ? a << sh :
        funct3 == F3_SLT  ? {31'b0, $signed(a) < $signed(b)} :
        funct3 == F3_SLTU ? {31'b0, a < b} :
        funct3 == F3_XOR  ? a ^ b :
        funct3 == F3_SR   ? (alt ? sra : a >> sh) :
        funct3 == F3_OR   ? a | b : a & b;
  end
endmodule

// File: rtl/ex_stage.sv
// ex_stage: RV32I execute stage with operand forwarding, branch resolution and EX/MEM register.
module ex_stage
  import rv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] id_ex_pc_in,
  input  logic [31:0] id_ex_pc_4_in,
  input  logic [31:0] id_ex_rs1_data_in,
  input  logic [31:0] id_ex_rs2_data_in,
  input  logic [31:0] id_ex_imm_in,
  input  logic [4:0]  id_ex_rd_in,
  input  logic [4:0]  id_ex_rs1_in,
  input  logic [4:0]  id_ex_rs2_in,
  input  logic [2:0]  id_ex_funct3_in,
  input  logic [6:0]  id_ex_funct7_in,
  input  logic [6:0]  id_ex_opcode_in,
  input  logic        mem_wb_reg_write_en_in,
  input  logic [4:0]  mem_wb_rd_in,
  input  logic [31:0] mem_wb_write_data_in,
  output logic        branch_taken_out,
  output logic [31:0] branch_target_out,
  output logic [31:0] ex_mem_alu_result_out,
  output logic [31:0] ex_mem_store_data_out,
  output logic [4:0]  ex_mem_rd_out,
  output logic [2:0]  ex_mem_funct3_out,
  output logic        ex_mem_mem_read_en_out,
  output logic        ex_mem_mem_write_en_out,
  output logic        ex_mem_reg_write_en_out,
  output logic        ex_mem_mem_to_reg_out
);
  ex_mem_t q, d;
  logic is_op, is_imm, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_auipc;
  logic alt, eq, lt, ltu, cond, unused_f7;
  logic [31:0] rs1_v, rs2_v, op_b, alu_y, sum;
  always_comb begin
    is_op = id_ex_opcode_in == OPC_OP;
    is_imm = id_ex_opcode_in == OPC_IMM;
    is_ld = id_ex_opcode_in == OPC_LOAD;
    is_st = id_ex_opcode_in == OPC_STORE;
    is_br = id_ex_opcode_in == OPC_BRANCH;
    is_jal = id_ex_opcode_in == OPC_JAL;
    is_jalr = id_ex_opcode_in == OPC_JALR;
    is_lui = id_ex_opcode_in == OPC_LUI;
    is_auipc = id_ex_opcode_in == OPC_AUIPC;
    rs1_v = forward(id_ex_rs1_in, q, mem_wb_reg_write_en_in, mem_wb_rd_in, mem_wb_write_data_in, id_ex_rs1_data_in);
    rs2_v = forward(id_ex_rs2_in, q, mem_wb_reg_write_en_in, mem_wb_rd_in, mem_wb_write_data_in, id_ex_rs2_data_in);
    op_b = (is_op || is_br) ? rs2_v : id_ex_imm_in;
    alt = id_ex_funct7_in[5] && (is_op || (is_imm && id_ex_funct3_in == F3_SR));
    unused_f7 = ^{id_ex_funct7_in[6], id_ex_funct7_in[4:0]};
  end
  alu alu_i (.a(rs1_v), .b(op_b), .funct3(id_ex_funct3_in), .alt(alt), .y(alu_y));
  always_comb begin
    sum = rs1_v + id_ex_imm_in;
    eq = rs1_v == rs2_v;
    lt = $signed(rs1_v) < $signed(rs2_v);
    ltu = rs1_v < rs2_v;
    cond = id_ex_funct3_in == BR_EQ  ? eq :
           id_ex_funct3_in == BR_NE  ? !eq :
           id_ex_funct3_in == BR_LT  ? lt :
           id_ex_funct3_in == BR_GE  ? !lt :
           id_ex_funct3_in == BR_LTU ? ltu :
           id_ex_funct3_in == BR_GEU ? !ltu : 1'b0;
    branch_taken_out = (is_br && cond) || is_jal || is_jalr;
    branch_target_out = !branch_taken_out ? 32'd0 :
                        is_jalr ? {sum[31:1], 1'b0} : id_ex_pc_in + id_ex_imm_in;
    d.result = (is_ld || is_st) ? sum :
               is_lui ? id_ex_imm_in :
               is_auipc ? id_ex_pc_in + id_ex_imm_in :
               (is_jal || is_jalr) ? id_ex_pc_4_in :
               (is_op || is_imm) ? alu_y : 32'd0;
    d.store_data = rs2_v;
    d.rd = id_ex_rd_in;
    d.funct3 = id_ex_funct3_in;
    d.mem_read = is_ld;
    d.mem_write = is_st;
    d.reg_write = (is_op || is_imm || is_ld || is_jal || is_jalr || is_lui || is_auipc) && id_ex_rd_in != 5'd0;
    d.mem_to_reg = is_ld;
  end
  always_ff @(posedge clk) q <= rst ? '0 : d;
  assign ex_mem_alu_result_out = q.result;
  assign ex_mem_store_data_out = q.store_data;
  assign ex_mem_rd_out = q.rd;
  assign ex_mem_funct3_out = q.funct3;
  assign ex_mem_mem_read_en_out = q.mem_read;
  assign ex_mem_mem_write_en_out = q.mem_write;
  assign ex_mem_reg_write_en_out = q.reg_write;
  assign ex_mem_mem_to_reg_out = q.mem_to_reg;
endmodule
